// File: rtl/control_sequencer.sv
// control_sequencer: microprogrammed control FSM for the accumulator processor.
// Fetches the instruction, decodes the opcode and issues one bus transfer per
// cycle (write_sel / read_sel) with a memory handshake.
// Optional build macro: SEQ_ILLEGAL_TRAP_EN (illegal opcode traps to HALT with
// a sticky illegal flag); otherwise an illegal opcode runs as a NOP.
module control_sequencer #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic               z_flag,
  input  logic               mem_ready,
  output logic [2:0]         write_sel,
  output logic               write_en,
  output logic [2:0]         read_sel,
  output logic [1:0]         alu_op,
  output logic               pc_inc,
  output logic               mem_req,
  output logic               halt,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_DEC, S_A1, S_A2, S_A3,
    S_L1, S_L2, S_S1, S_S2, S_X1, S_HALT
  } state_t;

  // register / bus source codes
  localparam logic [2:0] R_AC  = 3'b000;
  localparam logic [2:0] R_AR  = 3'b001;
  localparam logic [2:0] R_PC  = 3'b010;
  localparam logic [2:0] R_DR  = 3'b011;
  localparam logic [2:0] R_R   = 3'b101;
  localparam logic [2:0] R_IR  = 3'b110;
  localparam logic [2:0] R_MEM = 3'b111;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDAC = 4'b0001;
  localparam logic [3:0] OP_STAC = 4'b0010;
  localparam logic [3:0] OP_MVAC = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_JUMP = 4'b0101;
  localparam logic [3:0] OP_JMPZ = 4'b0110;
  localparam logic [3:0] OP_ADD  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state, state_n;
  logic [3:0] op_q;
  logic       z_q;
  logic [2:0] ws_c, rs_c;
  logic       we_c, pi_c, mr_c, ill_dec, cnt_inc;
  logic [1:0] alu_c;

  // next-state and per-state bus/strobe decode
  always_comb begin
    state_n = state;
    ws_c    = '0;
    rs_c    = '0;
    we_c    = 1'b0;
    alu_c   = '0;
    pi_c    = 1'b0;
    mr_c    = 1'b0;
    ill_dec = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_F1;
      S_F1: begin
        rs_c = R_PC; ws_c = R_AR; we_c = 1'b1;
        state_n = S_F2;
      end
      S_F2: begin
        rs_c = R_MEM; ws_c = R_IR; we_c = mem_ready; pi_c = mem_ready; mr_c = 1'b1;
        if (mem_ready) state_n = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_NOP:                             state_n = S_F1;
          OP_LDAC, OP_STAC, OP_JUMP, OP_JMPZ: state_n = S_A1;
          OP_MVAC, OP_MOVR, OP_ADD, OP_SUB:   state_n = S_X1;
          OP_HALT:                            state_n = S_HALT;
          default: begin
            ill_dec = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_n = S_HALT;
`else
            state_n = S_F1;
`endif
          end
        endcase
      end
      S_A1: begin
        rs_c = R_PC; ws_c = R_AR; we_c = 1'b1;
        state_n = S_A2;
      end
      S_A2: begin
        rs_c = R_MEM; ws_c = R_DR; we_c = mem_ready; pi_c = mem_ready; mr_c = 1'b1;
        if (mem_ready) state_n = (op_q == OP_JMPZ && !z_q) ? S_F1 : S_A3;
      end
      S_A3: begin
        rs_c = R_DR; we_c = 1'b1;
        if (op_q == OP_LDAC) begin
          ws_c = R_AR; state_n = S_L1;
        end else if (op_q == OP_STAC) begin
          ws_c = R_AR; state_n = S_S1;
        end else begin
          ws_c = R_PC; state_n = S_F1;
        end
      end
      S_L1: begin
        rs_c = R_MEM; ws_c = R_DR; we_c = mem_ready; mr_c = 1'b1;
        if (mem_ready) state_n = S_L2;
      end
      S_L2: begin
        rs_c = R_DR; ws_c = R_AC; we_c = 1'b1;
        state_n = S_F1;
      end
      S_S1: begin
        rs_c = R_AC; ws_c = R_DR; we_c = 1'b1;
        state_n = S_S2;
      end
      S_S2: begin
        rs_c = R_DR; ws_c = R_MEM; we_c = mem_ready; mr_c = 1'b1;
        if (mem_ready) state_n = S_F1;
      end
      S_X1: begin
        we_c = 1'b1;
        case (op_q)
          OP_MVAC: begin rs_c = R_AC; ws_c = R_R;  end
          OP_MOVR: begin rs_c = R_R;  ws_c = R_AC; end
          OP_ADD:  begin rs_c = R_R;  ws_c = R_AC; alu_c = 2'b01; end
          default: begin rs_c = R_R;  ws_c = R_AC; alu_c = 2'b10; end
        endcase
        state_n = S_F1;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
    // F1 is never re-entered from itself, so "state != IDLE" marks a retirement
    cnt_inc = (state_n == S_F1 && state != S_IDLE) ||
              (state_n == S_HALT && state != S_HALT);
  end

  // bus selects read as 000 whenever no transfer is being issued
  assign write_sel = we_c ? ws_c : '0;
  assign read_sel  = we_c ? rs_c : '0;
  assign write_en  = we_c;
  assign alu_op    = alu_c;
  assign pc_inc    = pi_c;
  assign mem_req   = mr_c;
  assign halt      = (state == S_HALT);

  // state register, opcode/flag capture in DEC, retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      z_q         <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_DEC) begin
        op_q <= opcode;
        z_q  <= z_flag;
      end
      if (cnt_inc) instr_count <= instr_count + COUNT_W'(1);
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;

  // sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       illegal_q <= 1'b0;
    else if (ill_dec) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q | ill_dec;
`else
  assign illegal = ill_dec;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle checks of the bus/strobe
// outputs against hand-derived microcode sequences, plus instr_count checks.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, z_flag, mem_ready;
  logic [3:0]  opcode;
  logic [2:0]  write_sel, read_sel;
  logic        write_en, pc_inc, mem_req, halt, illegal;
  logic [1:0]  alu_op;
  logic [15:0] instr_count;

  int vecs = 0;
  int errs = 0;

  control_sequencer #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .z_flag(z_flag),
    .mem_ready(mem_ready), .write_sel(write_sel), .write_en(write_en),
    .read_sel(read_sel), .alu_op(alu_op), .pc_inc(pc_inc), .mem_req(mem_req),
    .halt(halt), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // check outputs {write_sel,read_sel,write_en,alu_op,pc_inc,mem_req,halt,illegal}
  // for the current cycle, then advance one clock
  task automatic cyc(input string tag, input logic [2:0] ws, input logic [2:0] rs,
                     input logic we, input logic [1:0] alu, input logic pi,
                     input logic mr, input logic h, input logic il);
    #1;
    chk(tag, {19'd0, write_sel, read_sel, write_en, alu_op, pc_inc, mem_req, halt, illegal},
             {19'd0, ws, rs, we, alu, pi, mr, h, il});
    @(posedge clk); #1;
  endtask

  task automatic zero(input string tag);
    cyc(tag, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // F1, F2, DEC with zero wait states
  task automatic fetch(input string tag, input logic il);
    cyc({tag, "_F1"},  3'd1, 3'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc({tag, "_F2"},  3'd6, 3'd7, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc({tag, "_DEC"}, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, il);
  endtask

  task automatic a1a2(input string tag);
    cyc({tag, "_A1"}, 3'd1, 3'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc({tag, "_A2"}, 3'd3, 3'd7, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic xop(input string tag, input logic [3:0] op, input logic [2:0] ws,
                     input logic [2:0] rs, input logic [1:0] alu, input logic [15:0] cnt);
    opcode = op;
    fetch(tag, 1'b0);
    opcode = 4'h0;
    cyc({tag, "_X1"}, ws, rs, 1'b1, alu, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_cnt"}, {16'd0, instr_count}, {16'd0, cnt});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 4'h0; z_flag = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    zero("reset");
    chk("reset_cnt", {16'd0, instr_count}, 32'd0);
    rst_n = 1'b1;
    zero("idle_nostart");
    start = 1'b1;
    zero("idle_start");
    start = 1'b0;

    // NOP loop: 3 cycles each, count 1 then 2
    fetch("nop1", 1'b0);
    chk("nop1_cnt", {16'd0, instr_count}, 32'd1);
    fetch("nop2", 1'b0);
    chk("nop2_cnt", {16'd0, instr_count}, 32'd2);

    // LDAC with two wait cycles in L1 (10 cycles); opcode changes after DEC
    opcode = 4'h1;
    fetch("ldac", 1'b0);
    opcode = 4'h0;
    a1a2("ldac");
    cyc("ldac_A3", 3'd1, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    cyc("ldac_L1w0", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("ldac_L1w1", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cyc("ldac_L1", 3'd3, 3'd7, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("ldac_L2", 3'd0, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ldac_cnt", {16'd0, instr_count}, 32'd3);

    // STAC with one wait cycle in S2
    opcode = 4'h2;
    fetch("stac", 1'b0);
    opcode = 4'hF;
    a1a2("stac");
    cyc("stac_A3", 3'd1, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("stac_S1", 3'd3, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    cyc("stac_S2w", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cyc("stac_S2", 3'd7, 3'd3, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stac_cnt", {16'd0, instr_count}, 32'd4);

    // JMPZ not taken (z sampled 0 in DEC, then raised): back to F1 after A2
    opcode = 4'h6; z_flag = 1'b0;
    fetch("jmpz0", 1'b0);
    z_flag = 1'b1;
    a1a2("jmpz0");
    chk("jmpz0_cnt", {16'd0, instr_count}, 32'd5);

    // JMPZ taken (z sampled 1, then dropped): A3 writes PC from DR
    fetch("jmpz1", 1'b0);
    z_flag = 1'b0;
    a1a2("jmpz1");
    cyc("jmpz1_A3", 3'd2, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jmpz1_cnt", {16'd0, instr_count}, 32'd6);

    // JUMP with one wait cycle in F2
    opcode = 4'h5;
    cyc("jump_F1", 3'd1, 3'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    cyc("jump_F2w", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cyc("jump_F2", 3'd6, 3'd7, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("jump_DEC", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    a1a2("jump");
    cyc("jump_A3", 3'd2, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump_cnt", {16'd0, instr_count}, 32'd7);

    // single-cycle register/ALU group
    xop("add",  4'h7, 3'd0, 3'd5, 2'b01, 16'd8);
    xop("sub",  4'h8, 3'd0, 3'd5, 2'b10, 16'd9);
    xop("mvac", 4'h3, 3'd5, 3'd0, 2'b00, 16'd10);
    xop("movr", 4'h4, 3'd0, 3'd5, 2'b00, 16'd11);

    // asynchronous reset in the middle of a waiting A2
    opcode = 4'h1;
    fetch("rst", 1'b0);
    cyc("rst_A1", 3'd1, 3'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("rst_A2w", {29'd0, write_en, mem_req, pc_inc}, {29'd0, 3'b010});
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", {19'd0, write_sel, read_sel, write_en, alu_op, pc_inc, mem_req, halt, illegal}, 32'd0);
    chk("rst_async_cnt", {16'd0, instr_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1;
    zero("rst_idle0");
    zero("rst_idle1");
    start = 1'b1;
    zero("rst_start");
    start = 1'b0;

    // undefined opcode 1010
    opcode = 4'hA;
    fetch("ill", 1'b1);
`ifdef SEQ_ILLEGAL_TRAP_EN
    start = 1'b1;
    cyc("ill_halt0", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("ill_halt1", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ill_cnt", {16'd0, instr_count}, 32'd1);
    start = 1'b0;
`else
    chk("ill_cnt", {16'd0, instr_count}, 32'd1);
    // HALT opcode: halts and counts, start has no effect
    opcode = 4'hF;
    fetch("halt", 1'b0);
    opcode = 4'h0; start = 1'b1;
    cyc("halt0", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("halt1", 3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("halt_cnt", {16'd0, instr_count}, 32'd2);
    start = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microprogrammed control FSM for the accumulator processor. Fetches the instruction word, decodes `opcode`, and issues one bus transfer per cycle. It drives `write_sel` into the write-select decoder and `read_sel` into the bus source mux, and it handshakes with memory. It sits directly upstream of the write-select decoder and is the only source of its select code.

## Interface
- `COUNT_W`, default 16: width of the retired-instruction counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE and begin fetching. Ignored when not in IDLE.
- `opcode` in 4: IR[7:4], sampled in DEC.
- `z_flag` in 1: accumulator-zero flag, sampled in DEC.
- `mem_ready` in 1: memory completes the current access this cycle.
- `write_sel` out 3: destination code. 000 AC, 001 AR, 010 PC, 011 DR, 100 TR, 101 R, 110 IR, 111 memory write.
- `write_en` out 1: `write_sel` is meaningful. The decoder output must be gated by this.
- `read_sel` out 3: bus source code. Same encoding as `write_sel`; 111 means memory read data.
- `alu_op` out 2: 00 pass bus, 01 AC+R, 10 AC−R.
- `pc_inc` out 1: increment PC this cycle.
- `mem_req` out 1: memory access in progress.
- `halt` out 1: processor halted.
- `illegal` out 1: undefined opcode decoded.
- `instr_count` out COUNT_W: retired-instruction count.

## Operation
- States: IDLE, F1, F2, DEC, A1, A2, A3, L1, L2, S1, S2, X1, HALT.
- IDLE: all strobes 0. Goes to F1 when `start`=1.
- F1: read_sel=PC, write AR.
- F2: read_sel=MEM, write IR, mem_req=1. `write_en` and `pc_inc` are both driven combinationally equal to `mem_ready`. The FSM holds in F2 until `mem_ready`=1.
- DEC: no strobes. Branches on `opcode`:
  - 0000 NOP: go to F1.
  - 0001 LDAC, 0010 STAC, 0101 JUMP, 0110 JMPZ: go to A1.
  - 0011 MVAC, 0100 MOVR, 0111 ADD, 1000 SUB: go to X1.
  - 1111 HALT: go to HALT.
  - Any other opcode: illegal (see Configuration).
- Operand fetch:
  - A1: read_sel=PC, write AR.
  - A2: read_sel=MEM, write DR, pc_inc, mem_req. Waits on `mem_ready` exactly as F2 does.
  - After A2: JUMP goes to A3. JMPZ goes to A3 if `z_flag`=1 (as latched in DEC), otherwise to F1.
  - A3: read_sel=DR. LDAC/STAC write AR, then go to L1/S1. JUMP/JMPZ write PC, then go to F1.
- LDAC:
  - L1: read_sel=MEM, write DR, mem_req. Waits on `mem_ready`.
  - L2: read_sel=DR, write AC, go to F1.
- STAC:
  - S1: read_sel=AC, write DR.
  - S2: read_sel=DR, write_sel=111, mem_req. `write_en`=`mem_ready`; the FSM waits on `mem_ready`, then goes to F1.
- X1, a single cycle, then F1:
  - MVAC: read_sel=AC, write R.
  - MOVR: read_sel=R, write AC.
  - ADD: read_sel=R, alu_op=01, write AC.
  - SUB: read_sel=R, alu_op=10, write AC.
- HALT: halt=1 and all strobes 0. Only reset exits this state.
- `instr_count` increments by 1 on every transition into F1 from a non-IDLE state and on entry to HALT. It wraps modulo 2^COUNT_W.
- When `write_en`=0, `write_sel` is driven to 000 and `read_sel` to 000.

## Timing
- Reset value of every output is 0. State is IDLE and `instr_count` is 0.
- Reset is asynchronous: asserting it mid-access drops `mem_req` immediately, with no completion.
- Outputs are Moore decodes of the state. The exceptions are `write_en` and `pc_inc` in F2, A2, L1 and S2, which are combinationally ANDed with `mem_ready`.
- Instruction lengths with zero wait states, counted from F1 up to the next F1:
  - NOP: 3 cycles.
  - X1 group: 4.
  - JMPZ not taken: 5.
  - JUMP / JMPZ taken: 6.
  - LDAC: 8.
  - STAC: 8.
- Each cycle in which `mem_ready`=0 during F2, A2, L1 or S2 adds exactly 1 cycle.
- `opcode` and `z_flag` are captured only in DEC. Later changes to either have no effect.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode goes to HALT.
  - `illegal` becomes sticky at 1 until reset.
  - `instr_count` increments on this entry to HALT.
- `SEQ_ILLEGAL_TRAP_EN` not defined:
  - An illegal opcode is executed as a NOP.
  - `illegal` pulses high for the DEC cycle only.

## Test plan
- Reset, then `start`=1 with `opcode`=0000 and `mem_ready`=1 → F1/F2/DEC repeat every 3 cycles. `instr_count` reads 1 after the first DEC and 2 after the second.
- LDAC with `mem_ready` low for 2 cycles in L1 → instruction takes 10 cycles. `write_sel` sequence is 001, 110, 001, 011, 001, 011, 000. `write_en`=0 during the wait.
- STAC → S2 shows `write_sel`=111, `read_sel`=011, with `write_en` high only in the `mem_ready` cycle. `pc_inc` is seen exactly twice.
- JMPZ with `z_flag`=0 → 5 cycles, no PC write. With `z_flag`=1 → 6 cycles, and A3 shows `write_sel`=010, `read_sel`=011.
- `opcode`=1010:
  - With the macro: `halt`=1 and `illegal`=1 persist, and `instr_count` reads 1.
  - Without the macro: `illegal` is a 1-cycle pulse, then F1.
- `rst_n` low in mid-A2 with `mem_req`=1 → all outputs 0 within the same cycle, FSM in IDLE, and `start` is required to resume.
